// File: rtl/mux16_rr_scheduler_if.sv
// Signal bundle between the round-robin scheduler, its 16 requesters, the shared
// 16:1 mux tree and the downstream valid/ready consumer.
interface mux16_rr_scheduler_if;
  logic [15:0] req;
  logic        mux_out;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic [3:0]  out_ch;
  logic [15:0] done;
  logic        busy;

  modport master (
    input  req, mux_out, out_ready,
    output sel, grant, out_valid, out_bit, out_ch, done, busy
  );

  modport slave (
    output req, mux_out, out_ready,
    input  sel, grant, out_valid, out_bit, out_ch, done, busy
  );
endinterface

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler for a shared 16:1 bit-mux tree: arbitrate, drive select,
// wait one settle cycle, capture the bit and present it on a valid/ready port.
module mux16_rr_scheduler #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned SEL_W  = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  mux16_rr_scheduler_if.master   io_bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StPresent} state_e;

  state_e              r_state,     w_state_nxt;
  logic [SEL_W-1:0]    r_last_ptr,  w_last_ptr_nxt;
  logic [SEL_W-1:0]    r_sel,       w_sel_nxt;
  logic [NUM_CH-1:0]   r_grant,     w_grant_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_out_bit,   w_out_bit_nxt;
  logic [SEL_W-1:0]    r_out_ch,    w_out_ch_nxt;
  logic [NUM_CH-1:0]   r_done,      w_done_nxt;

  logic                w_found;
  logic [SEL_W-1:0]    w_winner;
  logic [SEL_W-1:0]    w_idx;

  // Search upward from last_ptr+1 with 4-bit wrap; first set request wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_idx = r_last_ptr + SEL_W'(k);
      if (!w_found && io_bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_ptr_nxt  = r_last_ptr;
    w_sel_nxt       = r_sel;
    w_grant_nxt     = r_grant;
    w_out_valid_nxt = r_out_valid;
    w_out_bit_nxt   = r_out_bit;
    w_out_ch_nxt    = r_out_ch;
    w_done_nxt      = '0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_sel_nxt    = w_winner;
          w_out_ch_nxt = w_winner;
          w_grant_nxt  = NUM_CH'(1) << w_winner;
          w_state_nxt  = StSettle;
        end
      end
      StSettle: begin
        w_out_bit_nxt   = io_bus.mux_out;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = StPresent;
      end
      StPresent: begin
        if (io_bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_grant_nxt     = '0;
          w_done_nxt      = r_grant;
          w_last_ptr_nxt  = r_out_ch;
          w_state_nxt     = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_last_ptr  <= SEL_W'(NUM_CH - 1);
      r_sel       <= '0;
      r_grant     <= '0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_ch    <= '0;
      r_done      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_ptr  <= w_last_ptr_nxt;
      r_sel       <= w_sel_nxt;
      r_grant     <= w_grant_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_bit   <= w_out_bit_nxt;
      r_out_ch    <= w_out_ch_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign io_bus.sel       = r_sel;
  assign io_bus.grant     = r_grant;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_bit   = r_out_bit;
  assign io_bus.out_ch    = r_out_ch;
  assign io_bus.done      = r_done;
  assign io_bus.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Bench for mux16_rr_scheduler: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mux16_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = 16'h0;
  logic        flip = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  mux16_rr_scheduler_if u_if ();

  mux16_rr_scheduler u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (u_if)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational mux tree.
  assign u_if.mux_out = data[u_if.sel] ^ flip;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 waiting for requests, 1 select settling, 2 bit on offer
  int          m_phase, m_last, m_ch;
  logic [3:0]  m_sel;
  logic        m_bit;
  logic [15:0] m_done;

  function automatic int pick(input logic [15:0] r, input int last);
    for (int k = 1; k <= 16; k++) begin
      int c;
      c = (last + k) % 16;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_last <= 15; m_ch <= 0; m_sel <= 4'd0; m_bit <= 1'b0; m_done <= 16'h0;
    end else begin
      m_done <= 16'h0;
      if (m_phase == 0) begin
        if (u_if.req != 16'h0) begin
          m_ch    <= pick(u_if.req, m_last);
          m_sel   <= 4'(pick(u_if.req, m_last));
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        m_bit   <= data[m_sel] ^ flip;
        m_phase <= 2;
      end else if (u_if.out_ready) begin
        m_done  <= 16'(1) << m_ch;
        m_last  <= m_ch;
        m_phase <= 0;
      end
    end
  end

  // ---------------- per-cycle compare + grant log ----------------
  int          grant_q[$];
  int          rise_q[$];
  int          cyc = 0;
  logic [15:0] prev_grant = 16'h0;

  always @(negedge clk) begin
    cyc++;
    chk("sel", 32'(u_if.sel), 32'(m_sel));
    chk("grant", 32'(u_if.grant), (m_phase != 0) ? (32'd1 << m_ch) : 32'd0);
    chk("busy", 32'(u_if.busy), 32'(m_phase != 0));
    chk("out_valid", 32'(u_if.out_valid), 32'(m_phase == 2));
    chk("out_bit", 32'(u_if.out_bit), 32'(m_bit));
    chk("out_ch", 32'(u_if.out_ch), 32'(m_ch));
    chk("done", 32'(u_if.done), 32'(m_done));
    if (prev_grant == 16'h0 && u_if.grant != 16'h0) begin
      for (int i = 0; i < 16; i++) if (u_if.grant[i]) grant_q.push_back(i);
      rise_q.push_back(cyc);
    end
    prev_grant = u_if.grant;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    u_if.req = 16'h0;
    u_if.out_ready = 1'b1;
    tick(2);
    chk("rst_sel", 32'(u_if.sel), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_valid", 32'(u_if.out_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // single request on ch5
    data = 16'h0020;
    u_if.req = 16'h0020;
    tick();
    chk("t1_sel", 32'(u_if.sel), 32'd5);
    chk("t1_grant", 32'(u_if.grant), 32'h0020);
    chk("t1_busy", 32'(u_if.busy), 32'd1);
    tick();
    chk("t1_valid", 32'(u_if.out_valid), 32'd1);
    chk("t1_bit", 32'(u_if.out_bit), 32'd1);
    chk("t1_ch", 32'(u_if.out_ch), 32'd5);
    tick();
    chk("t1_done", 32'(u_if.done), 32'h0020);
    chk("t1_idle", 32'(u_if.busy), 32'd0);
    chk("t1_grant_clr", 32'(u_if.grant), 32'd0);
    u_if.req = 16'h0;
    tick();
    chk("t1_done_pulse", 32'(u_if.done), 32'd0);

    // round robin from reset: 17 grants, one every 3 cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    grant_q.delete();
    rise_q.delete();
    data = 16'hA5C3;
    u_if.req = 16'hFFFF;
    tick(51);
    u_if.req = 16'h0;
    tick(2);
    chk("rr_count", 32'(grant_q.size()), 32'd17);
    for (int i = 0; i < grant_q.size(); i++) chk("rr_order", 32'(grant_q[i]), 32'(i % 16));
    for (int i = 1; i < rise_q.size(); i++) chk("rr_interval", 32'(rise_q[i] - rise_q[i-1]), 32'd3);

    // fairness skip: serve ch3, then {0,3} -> ch0 first, then ch3
    grant_q.delete();
    u_if.req = 16'h0008;
    tick(3);
    u_if.req = 16'h0009;
    tick(6);
    u_if.req = 16'h0;
    tick(2);
    chk("fair_count", 32'(grant_q.size()), 32'd3);
    if (grant_q.size() == 3) begin
      chk("fair_0", 32'(grant_q[0]), 32'd3);
      chk("fair_1", 32'(grant_q[1]), 32'd0);
      chk("fair_2", 32'(grant_q[2]), 32'd3);
    end

    // backpressure on ch10 while mux_out toggles
    data = 16'h0400;
    flip = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.req = 16'h0400;
    tick(2);
    chk("bp_valid", 32'(u_if.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      flip = ~flip;
      tick();
      chk("bp_bit", 32'(u_if.out_bit), 32'd1);
      chk("bp_ch", 32'(u_if.out_ch), 32'd10);
      chk("bp_sel", 32'(u_if.sel), 32'd10);
      chk("bp_grant", 32'(u_if.grant), 32'h0400);
      chk("bp_nodone", 32'(u_if.done), 32'd0);
    end
    u_if.out_ready = 1'b1;
    tick();
    chk("bp_done", 32'(u_if.done), 32'h0400);
    u_if.req = 16'h0;
    flip = 1'b0;
    tick();

    // request withdrawn during settle still completes
    u_if.req = 16'h0100;
    tick();
    u_if.req = 16'h0;
    tick();
    chk("wd_ch", 32'(u_if.out_ch), 32'd8);
    chk("wd_valid", 32'(u_if.out_valid), 32'd1);
    tick();
    chk("wd_done", 32'(u_if.done), 32'h0100);
    tick();
    chk("wd_idle", 32'(u_if.busy), 32'd0);

    // reset during PRESENT discards the transfer
    u_if.out_ready = 1'b0;
    u_if.req = 16'h0080;
    tick(2);
    chk("mr_valid", 32'(u_if.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", 32'(u_if.out_valid), 32'd0);
    chk("mr_rst_grant", 32'(u_if.grant), 32'd0);
    chk("mr_rst_sel", 32'(u_if.sel), 32'd0);
    chk("mr_rst_busy", 32'(u_if.busy), 32'd0);
    u_if.out_ready = 1'b1;
    tick();
    chk("mr_nodone", 32'(u_if.done), 32'd0);
    rst_n = 1'b1;
    u_if.req = 16'h0081;
    tick();
    chk("mr_first", 32'(u_if.grant), 32'h0001);
    tick(2);
    u_if.req = 16'h0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
